// File: rtl/ax_level_ctrl.sv
// Run-time approximation level: CSR-writable, adaptively tuned once per window of committed instructions.
// All outputs registered (CSR or window-end effect visible next cycle); no handshake, the level is a steady-state value.
module ax_level_ctrl #(
    parameter int LEVEL_WIDTH   = 5,
    parameter int DEFAULT_LEVEL = 10,
    parameter int MAX_LEVEL     = 20,
    parameter int COMMIT_WIDTH  = 2,
    parameter int WINDOW        = 256,
    parameter int ERR_HI        = 8,
    parameter int ERR_LO        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csrLevelWE,
    input  logic [LEVEL_WIDTH-1:0]  csrLevelData,
    input  logic                    csrModeWE,
    input  logic                    csrModeData,
    input  logic [COMMIT_WIDTH-1:0] commitValid,
    input  logic [COMMIT_WIDTH-1:0] axViolation,
    output logic [LEVEL_WIDTH-1:0]  axLevel,
    output logic                    adaptiveEn,
    output logic                    levelChanged
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int POP_W = $clog2(COMMIT_WIDTH + 1);

    localparam logic [LEVEL_WIDTH-1:0] LVL_MAX = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] LVL_DEF = LEVEL_WIDTH'(DEFAULT_LEVEL);
    localparam logic [SUM_W-1:0]       WIN_S   = SUM_W'(WINDOW);
    localparam logic [CNT_W-1:0]       WIN_C   = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0]       HI_C    = CNT_W'(ERR_HI);
    localparam logic [CNT_W-1:0]       LO_C    = CNT_W'(ERR_LO);

    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_mode;
    logic [CNT_W-1:0]       r_win_cnt;
    logic [CNT_W-1:0]       r_viol_cnt;
    logic                   r_changed;

    logic [POP_W-1:0]       w_n_commit;
    logic [POP_W-1:0]       w_n_viol;
    logic [SUM_W-1:0]       w_win_sum;
    logic [SUM_W-1:0]       w_viol_sum;
    logic [CNT_W-1:0]       w_viol_sat;
    logic                   w_win_end;
    logic [LEVEL_WIDTH-1:0] w_csr_level;
    logic [LEVEL_WIDTH-1:0] w_level_nxt;
    logic                   w_mode_nxt;
    logic [CNT_W-1:0]       w_win_nxt;
    logic [CNT_W-1:0]       w_viol_nxt;

    always_comb begin
        w_n_commit = '0;
        w_n_viol   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_n_commit = w_n_commit + POP_W'(commitValid[i]);
            w_n_viol   = w_n_viol + POP_W'(commitValid[i] & axViolation[i]);
        end
    end

    assign w_win_sum   = SUM_W'(r_win_cnt) + SUM_W'(w_n_commit);
    assign w_viol_sum  = SUM_W'(r_viol_cnt) + SUM_W'(w_n_viol);
    assign w_viol_sat  = (w_viol_sum >= WIN_S) ? WIN_C : w_viol_sum[CNT_W-1:0];
    assign w_win_end   = (w_win_sum >= WIN_S);
    assign w_csr_level = (csrLevelData > LVL_MAX) ? LVL_MAX : csrLevelData;

    // Any CSR write restarts the window; commits past the window end are dropped.
    always_comb begin
        w_level_nxt = r_level;
        w_mode_nxt  = r_mode;
        w_win_nxt   = '0;
        w_viol_nxt  = '0;
        if (csrModeWE) begin
            w_mode_nxt = csrModeData;
        end
        if (csrLevelWE) begin
            w_level_nxt = w_csr_level;
        end
        if (!csrLevelWE && !csrModeWE && r_mode) begin
            if (w_win_end) begin
                if (w_viol_sat >= HI_C) begin
                    w_level_nxt = (r_level == '0) ? '0 : r_level - 1'b1;
                end else if (w_viol_sat < LO_C) begin
                    w_level_nxt = (r_level >= LVL_MAX) ? LVL_MAX : r_level + 1'b1;
                end
            end else begin
                w_win_nxt  = w_win_sum[CNT_W-1:0];
                w_viol_nxt = w_viol_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level    <= LVL_DEF;
            r_mode     <= 1'b0;
            r_win_cnt  <= '0;
            r_viol_cnt <= '0;
            r_changed  <= 1'b0;
        end else begin
            r_level    <= w_level_nxt;
            r_mode     <= w_mode_nxt;
            r_win_cnt  <= w_win_nxt;
            r_viol_cnt <= w_viol_nxt;
            r_changed  <= (w_level_nxt != r_level);
        end
    end

    assign axLevel      = r_level;
    assign adaptiveEn   = r_mode;
    assign levelChanged = r_changed;

endmodule

// File: tb/tb_ax_level_ctrl.sv
module tb_ax_level_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       csrLevelWE;
    logic [4:0] csrLevelData;
    logic       csrModeWE;
    logic       csrModeData;
    logic [1:0] commitValid;
    logic [1:0] axViolation;
    logic [4:0] axLevel;
    logic       adaptiveEn;
    logic       levelChanged;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ax_level_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .csrLevelWE   (csrLevelWE),
        .csrLevelData (csrLevelData),
        .csrModeWE    (csrModeWE),
        .csrModeData  (csrModeData),
        .commitValid  (commitValid),
        .axViolation  (axViolation),
        .axLevel      (axLevel),
        .adaptiveEn   (adaptiveEn),
        .levelChanged (levelChanged)
    );

    // A vector holds cv/av for 'cycles' cycles; CSR strobes only on the first.
    // av is applied only on cycles where c % every == 0 (every = 0: always).
    typedef struct {
        logic       rst;
        logic       lwe;
        logic [4:0] ldat;
        logic       mwe;
        logic       mdat;
        logic [1:0] cv;
        logic [1:0] av;
        int         every;
        int         cycles;
        int         e_lvl;
        int         e_mode;
        int         e_chg;
        int         e_win;
        int         e_viol;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic lwe, logic [4:0] ldat, logic mwe, logic mdat,
                                logic [1:0] cv, logic [1:0] av, int every, int cycles,
                                int e_lvl, int e_mode, int e_chg, int e_win, int e_viol);
        vec_t v;
        v.rst = r; v.lwe = lwe; v.ldat = ldat; v.mwe = mwe; v.mdat = mdat;
        v.cv = cv; v.av = av; v.every = every; v.cycles = cycles;
        v.e_lvl = e_lvl; v.e_mode = e_mode; v.e_chg = e_chg; v.e_win = e_win; v.e_viol = e_viol;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; csrLevelWE = 1'b0; csrLevelData = '0; csrModeWE = 1'b0;
        csrModeData = 1'b0; commitValid = '0; axViolation = '0;
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int second_pulse;

        idle();
        //              rst lwe ldat mwe md  cv     av  evry cyc  lvl m chg win viol
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 2'b00, 2'b00, 0,   2, 10, 0, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5'd31, 0, 0, 2'b00, 2'b00, 0,   1, 20, 0, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b00, 2'b00, 0,   1, 20, 0, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5'd20, 0, 0, 2'b00, 2'b00, 0,   1, 20, 0, 0,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b11, 0,   5, 20, 0, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5'd10, 1, 1, 2'b00, 2'b00, 0,   1, 10, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b01, 16, 127, 10, 1, 0, 254,  8));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0,   1,  9, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0, 127,  9, 1, 0, 254,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0,   1, 10, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0, 128, 11, 1, 1,   0,  0));
        vecs.push_back(mk(0, 1, 5'd0,  0, 0, 2'b00, 2'b00, 0,   1,  0, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b01, 16, 128,  0, 1, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5'd20, 0, 0, 2'b00, 2'b00, 0,   1, 20, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0, 128, 20, 1, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5'd12, 0, 0, 2'b00, 2'b00, 0,   1, 12, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b01, 19, 128, 12, 1, 0,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b01, 128, 128, 12, 1, 0,  0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b01, 2'b10, 0, 255, 12, 1, 0, 255,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b10, 0,   1, 12, 1, 0,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0, 127, 12, 1, 0, 254,  0));
        vecs.push_back(mk(0, 1, 5'd5,  0, 0, 2'b11, 2'b00, 0,   1,  5, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0,  10,  5, 1, 0,  20,  0));
        vecs.push_back(mk(0, 0, 5'd0,  1, 0, 2'b11, 2'b00, 0,   1,  5, 0, 0,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b11, 0, 300,  5, 0, 0,   0,  0));
        vecs.push_back(mk(0, 1, 5'd15, 1, 1, 2'b00, 2'b00, 0,   1, 15, 1, 1,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b11, 0,  50, 15, 1, 0, 100, 100));
        vecs.push_back(mk(1, 0, 5'd0,  0, 0, 2'b00, 2'b00, 0,   1, 10, 0, 0,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  1, 1, 2'b00, 2'b00, 0,   1, 10, 1, 0,   0,  0));
        vecs.push_back(mk(0, 0, 5'd0,  0, 0, 2'b11, 2'b00, 0,  20, 10, 1, 0,  40,  0));
        vecs.push_back(mk(0, 0, 5'd0,  1, 1, 2'b11, 2'b00, 0,   1, 10, 1, 0,   0,  0));

        @(posedge clk); #1;
        foreach (vecs[k]) begin
            for (int c = 0; c < vecs[k].cycles; c++) begin
                rst          = vecs[k].rst;
                csrLevelWE   = (c == 0) ? vecs[k].lwe : 1'b0;
                csrLevelData = vecs[k].ldat;
                csrModeWE    = (c == 0) ? vecs[k].mwe : 1'b0;
                csrModeData  = vecs[k].mdat;
                commitValid  = vecs[k].cv;
                axViolation  = (vecs[k].every == 0 || (c % vecs[k].every) == 0) ? vecs[k].av : 2'b00;
                @(posedge clk); #1;
            end
            idle();
            chk($sformatf("v%0d_level", k),   int'(axLevel),        vecs[k].e_lvl);
            chk($sformatf("v%0d_mode", k),    int'(adaptiveEn),     vecs[k].e_mode);
            chk($sformatf("v%0d_changed", k), int'(levelChanged),   vecs[k].e_chg);
            chk($sformatf("v%0d_wincnt", k),  int'(dut.r_win_cnt),  vecs[k].e_win);
            chk($sformatf("v%0d_violcnt", k), int'(dut.r_viol_cnt), vecs[k].e_viol);
        end

        // Continuous dual commits from a fresh window: evaluations land every 128 cycles.
        pulses = 0; first_pulse = -1; second_pulse = -1;
        commitValid = 2'b11;
        for (int c = 1; c <= 256; c++) begin
            @(posedge clk); #1;
            if (levelChanged) begin
                pulses++;
                if (pulses == 1) first_pulse = c;
                if (pulses == 2) second_pulse = c;
            end
        end
        idle();
        chk("cont_pulse_count", pulses, 2);
        chk("cont_first_eval",  first_pulse, 128);
        chk("cont_second_eval", second_pulse, 256);
        chk("cont_level",       int'(axLevel), 12);
        @(posedge clk); #1;
        chk("cont_pulse_drop",  int'(levelChanged), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
